hazard_stall_unit: RTL and testbench

- Control-hazard and stall generator paired with the EX-stage forwarding unit; covers the hazards forwarding cannot resolve.
- Detects load-use hazards in ID and inserts one bubble.
- Freezes the whole pipeline while a data-memory access in MEM is not ready.
- Flushes IF/ID and ID/EX on a taken branch or jump resolved in EX.
- Keeps a memory-wait timeout watchdog and saturating stall/flush performance counters.

---
 rtl/hazard_stall_unit_pkg.sv | 20 ++
 rtl/hazard_stall_unit_if.sv | 40 ++++
 rtl/hazard_stall_unit_sat_counter.sv | 23 ++
 rtl/hazard_stall_unit.sv | 127 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline constants and types for the hazard/stall unit.
// Register write enables in this pipeline are active-low.
package hazard_stall_unit_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;
  localparam logic       WB_EN  = 1'b0;
  localparam logic       WB_DIS = 1'b1;

  typedef enum logic {
    ST_RUN,
    ST_WAIT
  } hsu_state_t;

  // True when an instruction actually reads 'src' and it names 'rd'.
  function automatic logic reg_match(input logic uses, input logic [4:0] src,
                                     input logic [4:0] rd);
    return uses && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side view of the hazard/stall unit: hazard inputs, control outputs
// and performance counters. The pipeline is master, the unit is slave.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 32
) ();
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       idex_rd;
  logic             idex_memread;
  logic             idex_wb;
  logic             dmem_valid;
  logic             dmem_ready;
  logic             branch_taken;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_bubble;
  logic             idex_stall;
  logic             exmem_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, idex_rd, idex_memread,
           idex_wb, dmem_valid, dmem_ready, branch_taken,
    input  pc_stall, ifid_stall, idex_bubble, idex_stall, exmem_stall,
           ifid_flush, idex_flush, mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, idex_rd, idex_memread,
           idex_wb, dmem_valid, dmem_ready, branch_taken,
    output pc_stall, ifid_stall, idex_bubble, idex_stall, exmem_stall,
           ifid_flush, idex_flush, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use bubble, memory-wait freeze and branch flush generation, with a
// sticky memory-wait watchdog and saturating stall/flush counters.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_unit_if.slave  bus
);

  hsu_state_t           state_reg, state_next;
  logic [TIMEOUT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic                 timeout_reg, timeout_next;

  logic freeze;
  logic lu;
  logic pc_stall, ifid_stall, idex_bubble, idex_stall, exmem_stall;
  logic ifid_flush, idex_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign freeze = bus.dmem_valid & ~bus.dmem_ready;

  // A load whose result is not yet available to forwarding, feeding ID.
  assign lu = bus.idex_memread & (bus.idex_wb == WB_EN) & (bus.idex_rd != REG_X0) &
              (reg_match(bus.id_uses_rs1, bus.id_rs1, bus.idex_rd) |
               reg_match(bus.id_uses_rs2, bus.id_rs2, bus.idex_rd));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_RUN;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    timeout_next  = timeout_reg;
    case (state_reg)
      ST_RUN: begin
        if (freeze) begin
          state_next    = ST_WAIT;
          wait_cnt_next = TIMEOUT_W'(1);
        end
      end
      ST_WAIT: begin
        if (wait_cnt_reg == TIMEOUT_W'(MEM_TIMEOUT)) begin
          timeout_next = 1'b1;
        end
        if (freeze) begin
          if (wait_cnt_reg != '1) begin
            wait_cnt_next = wait_cnt_reg + TIMEOUT_W'(1);
          end
        end else begin
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end
      end
      default: begin
        state_next    = ST_RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Freeze is decoded straight from the request so the very first wait
  // cycle is already stalled; EX is held, so a branch there is re-presented.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (!reset) begin
      if (freeze) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
      end else if (bus.branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_stall),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifid_flush),
    .cnt   (flush_cnt)
  );

  assign bus.pc_stall     = pc_stall;
  assign bus.ifid_stall   = ifid_stall;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.idex_stall   = idex_stall;
  assign bus.exmem_stall  = exmem_stall;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.mem_timeout  = timeout_reg;
  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_count  = flush_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and randomized checks of hazard_stall_unit against a cycle-level
// reference model built from run lengths and plain counters.
module tb_hazard_stall_unit;

  localparam int CNT_W   = 4;
  localparam int MT      = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int RUN_MAX = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_unit #(
    .CNT_W       (CNT_W),
    .TIMEOUT_W   (8),
    .MEM_TIMEOUT (MT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: consecutive frozen cycles so far, sticky flag, counters.
  int   run_len   = 0;
  logic m_timeout = 1'b0;
  int   m_stall   = 0;
  int   m_flush   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_lu(input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic u1, input logic u2,
                                    input logic [4:0] rd, input logic mr, input logic wb);
    if (!mr || wb || rd == 5'd0) return 1'b0;
    return (u1 && rs1 == rd) || (u2 && rs2 == rd);
  endfunction

  // One pipeline cycle: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic wb, input logic dv, input logic dr,
                      input logic br);
    logic       fz;
    logic [6:0] exp_ctrl;
    logic [6:0] got_ctrl;
    @(negedge clk);
    reset            = rst;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_uses_rs1  = u1;
    bus.id_uses_rs2  = u2;
    bus.idex_rd      = rd;
    bus.idex_memread = mr;
    bus.idex_wb      = wb;
    bus.dmem_valid   = dv;
    bus.dmem_ready   = dr;
    bus.branch_taken = br;
    #1;
    fz = dv && !dr;
    // {pc_stall, ifid_stall, idex_bubble, idex_stall, exmem_stall, ifid_flush, idex_flush}
    if (rst)                                    exp_ctrl = 7'b0000000;
    else if (fz)                                exp_ctrl = 7'b1101100;
    else if (br)                                exp_ctrl = 7'b0000011;
    else if (model_lu(rs1, rs2, u1, u2, rd, mr, wb)) exp_ctrl = 7'b1110000;
    else                                        exp_ctrl = 7'b0000000;
    got_ctrl = {bus.pc_stall, bus.ifid_stall, bus.idex_bubble, bus.idex_stall,
                bus.exmem_stall, bus.ifid_flush, bus.idex_flush};
    chk("ctrl", 32'(got_ctrl), 32'(exp_ctrl));
    chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stall));
    chk("flush_count", 32'(bus.flush_count), 32'(m_flush));
    chk("mem_timeout", 32'(bus.mem_timeout), 32'(m_timeout));
    $display("t=%0t rst=%0b fz=%0b br=%0b ctrl=%b stall=%0d flush=%0d to=%0b",
             $time, rst, fz, br, got_ctrl, bus.stall_cycles, bus.flush_count,
             bus.mem_timeout);
    @(posedge clk);
    if (rst) begin
      run_len = 0; m_timeout = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (run_len == MT) m_timeout = 1'b1;
      run_len = fz ? ((run_len < RUN_MAX) ? run_len + 1 : RUN_MAX) : 0;
      if (exp_ctrl[6] && m_stall < CNT_MAX) m_stall++;
      if (exp_ctrl[1] && m_flush < CNT_MAX) m_flush++;
    end
  endtask

  task automatic idle(input logic rst);
    step(rst, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic freeze_cycles(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.idex_rd = '0; bus.idex_memread = 0; bus.idex_wb = 1; bus.dmem_valid = 0;
    bus.dmem_ready = 0; bus.branch_taken = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state, then load-use on rs1 for a single cycle
    idle(1'b0);
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // No hazard: x0 destination, no source used, write disabled
    idle(1'b1);
    step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Branch beats load-use on rs2
    step(1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);

    // Three-cycle freeze, with a branch presented during it, then ready
    idle(1'b1);
    freeze_cycles(2);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b0);

    // Watchdog: six frozen cycles, flag stays after release
    freeze_cycles(6);
    repeat (3) idle(1'b0);

    // Reset mid-wait after ten stall cycles, then check saturation
    idle(1'b1);
    freeze_cycles(10);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    freeze_cycles(20);
    idle(1'b0);

    // Randomized traffic with a small register pool to provoke matches
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
           1'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) < 3), 1'($urandom),
           ($urandom_range(0, 99) < 15));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
